ov7670_config_seq: RTL and testbench

//  Sequences the OV7670 register-init ROM into the SCCB master after power-up or on request.

---
 rtl/ov7670_cfg_pkg.sv | 26 ++
 rtl/ov7670_config_seq_timer.sv | 27 ++
 rtl/ov7670_config_seq.sv | 173 +++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared state codes, ROM sentinels and helpers for the OV7670 config sequencer.
package ov7670_cfg_pkg;

    typedef logic [3:0] cfg_state_t;

    localparam cfg_state_t S_IDLE      = 4'd0;
    localparam cfg_state_t S_FETCH     = 4'd1;
    localparam cfg_state_t S_DECODE    = 4'd2;
    localparam cfg_state_t S_ISSUE     = 4'd3;
    localparam cfg_state_t S_WAIT_BUSY = 4'd4;
    localparam cfg_state_t S_WAIT_IDLE = 4'd5;
    localparam cfg_state_t S_DELAY     = 4'd6;
    localparam cfg_state_t S_NEXT      = 4'd7;
    localparam cfg_state_t S_DONE      = 4'd8;

    localparam logic [15:0] CFG_END      = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY    = 16'hFFF0;
    localparam logic [7:0]  CFG_ADDR_MAX = 8'hFF;

    localparam int unsigned TMR_W = 18;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ov7670_config_seq_timer.sv
// Loadable down-counter shared by the settle delay and the write timeout.
module cfg_wait_timer
    import ov7670_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 init ROM and feeds each entry to the SCCB write master.
// Optional per-write timeout: define CFG_SEQ_TIMEOUT_EN.
module ov7670_config_seq
    import ov7670_cfg_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES   = 250_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  wr_count
);

    localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES);

    cfg_state_t r_state;
    logic [7:0] r_addr;
    logic [7:0] r_reg;
    logic [7:0] r_val;
    logic       r_start;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_wr_count;
    logic       r_auto;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic             w_timeout;

    // The timer is reloaded on every non-end entry; it only counts where it matters.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        if ((r_state == S_DECODE) && (rom_dout != CFG_END)) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = (rom_dout == CFG_DELAY) ? DLY_LOAD : TMO_LOAD;
        end
    end

`ifdef CFG_SEQ_TIMEOUT_EN
    logic w_xfer;
    assign w_xfer    = (r_state == S_ISSUE)
                    || (r_state == S_WAIT_BUSY)
                    || (r_state == S_WAIT_IDLE);
    assign w_tmr_dec = (r_state == S_DELAY) || w_xfer;
    assign w_timeout = w_xfer && w_tmr_zero;
`else
    assign w_tmr_dec = (r_state == S_DELAY);
    assign w_timeout = 1'b0;
`endif

    cfg_wait_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 8'd0;
            r_reg      <= 8'd0;
            r_val      <= 8'd0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_count <= 8'd0;
            r_auto     <= AUTO_START;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start || r_auto) begin
                        r_auto     <= 1'b0;
                        r_addr     <= 8'd0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_wr_count <= 8'd0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (rom_dout == CFG_END) begin
                        r_state <= S_DONE;
                    end else if (rom_dout == CFG_DELAY) begin
                        r_state <= S_DELAY;
                    end else begin
                        r_reg   <= rom_dout[15:8];
                        r_val   <= rom_dout[7:0];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sccb_ready) begin
                        r_start <= 1'b1;
                        r_state <= S_WAIT_BUSY;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_NEXT;
                    end
                end
                // ready may still be high from before the accept; wait for it to drop.
                S_WAIT_BUSY: begin
                    if (!sccb_ready) begin
                        r_state <= S_WAIT_IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_NEXT;
                    end
                end
                S_WAIT_IDLE: begin
                    if (sccb_ready) begin
                        r_wr_count <= sat_inc8(r_wr_count);
                        r_state    <= S_NEXT;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_NEXT;
                    end
                end
                S_DELAY: begin
                    if (w_tmr_zero) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_addr == CFG_ADDR_MAX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 8'd1;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign sccb_start = r_start;
    assign sccb_reg   = r_reg;
    assign sccb_val   = r_val;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Scenario bench for ov7670_config_seq: ROM model, SCCB master model, scoreboard.
`timescale 1ns/1ps
module tb_ov7670_config_seq;

    localparam int DLY = 8;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    logic        sccb_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  wr_count;

    logic [15:0] rom [256];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          start_cyc[$];
    int          cmpl_cyc[$];
    logic [7:0]  exp_wr;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          obs_rd = 0;
    int          m_hold = 3;
    int          m_long_idx = -1;

    int unsigned mon_unstable = 0;
    int unsigned mon_start_low = 0;
    int unsigned mon_nonmono = 0;
    logic        mon_active = 1'b0;
    logic [15:0] mon_word = 16'h0;
    logic [7:0]  mon_prev_addr = 8'h0;
    logic        mon_prev_ready = 1'b1;

    ov7670_config_seq #(
        .DELAY_CYCLES   (DLY),
        .TIMEOUT_CYCLES (TMO),
        .AUTO_START     (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .sccb_start (sccb_start),
        .sccb_reg   (sccb_reg),
        .sccb_val   (sccb_val),
        .sccb_ready (sccb_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read config ROM.
    always @(posedge clk) rom_dout <= rom[rom_addr];

    // SCCB master: accepts a start, drops ready, holds it low, raises it again.
    initial begin : bfm
        int hold;
        sccb_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (sccb_start === 1'b1 && rst === 1'b0) begin
                obs_q.push_back({sccb_reg, sccb_val});
                start_cyc.push_back(int'(cyc));
                hold = (start_cyc.size() - 1 == m_long_idx) ? 80 : m_hold;
                @(posedge clk);
                #1 sccb_ready = 1'b0;
                repeat (hold) @(posedge clk);
                #1 sccb_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_active    = 1'b0;
            mon_prev_addr = 8'h0;
        end else begin
            if (sccb_start === 1'b1 && sccb_ready === 1'b0) mon_start_low++;
            if (sccb_start === 1'b1) begin
                mon_active = 1'b1;
                mon_word   = {sccb_reg, sccb_val};
            end else if (mon_active) begin
                if ({sccb_reg, sccb_val} !== mon_word) mon_unstable++;
                if (sccb_ready === 1'b1) mon_active = 1'b0;
            end
            if (busy === 1'b1 && rom_addr < mon_prev_addr) mon_nonmono++;
            mon_prev_addr = (busy === 1'b1) ? rom_addr : 8'h0;
        end
        if (sccb_ready === 1'b1 && mon_prev_ready === 1'b0) cmpl_cyc.push_back(int'(cyc));
        mon_prev_ready = sccb_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end by 1 ms expected summary");
        $fatal(1, "watchdog expired");
    end

    // Reference walk of the ROM image: expected writes and final wr_count.
    task automatic build_expect();
        int n = 0;
        exp_q.delete();
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) break;
            if (rom[a] != 16'hFFF0) begin
                exp_q.push_back(rom[a]);
                n++;
            end
        end
        exp_wr = (n > 255) ? 8'd255 : 8'(n);
    endtask

    task automatic set_rom4(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
        build_expect();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (rom_addr !== 8'h0) begin n_errors++; $display("FAIL rst_addr: got %h expected 00", rom_addr); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", err); end
        n_checks++; if (wr_count !== 8'h0) begin n_errors++; $display("FAIL rst_wrcnt: got %h expected 00", wr_count); end
        n_checks++; if (sccb_start !== 1'b0) begin n_errors++; $display("FAIL rst_start: got %b expected 0", sccb_start); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_noauto: got busy %b expected 0", busy); end
    endtask

    task automatic test_basic();
        bit ok;
        int s0, c0, gap;
        logic [15:0] w;
        set_rom4(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF);
        m_hold = 3;
        obs_rd = obs_q.size();
        s0 = start_cyc.size();
        c0 = cmpl_cyc.size();
        pulse_start();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_clr: got %b expected 0", done); end
        wait_idle(2000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_timeout: got busy %b expected 0", busy); end
        n_checks++; if (start_cyc.size() - s0 != 2) begin n_errors++; $display("FAIL basic_pulses: got %0d expected 2", start_cyc.size() - s0); end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin n_errors++; $display("FAIL basic_wr: got none expected %h", w); end
            else begin
                if (obs_q[obs_rd] !== w) begin n_errors++; $display("FAIL basic_wr: got %h expected %h", obs_q[obs_rd], w); end
                obs_rd++;
            end
        end
        n_checks++;
        if (start_cyc.size() < s0 + 2 || cmpl_cyc.size() < c0 + 1) begin
            n_errors++; $display("FAIL basic_gap: got too few events expected 2 writes");
        end else begin
            gap = start_cyc[s0 + 1] - cmpl_cyc[c0];
            if (gap < DLY + 1) begin n_errors++; $display("FAIL basic_gap: got %0d expected >= %0d", gap, DLY + 1); end
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b expected 1", done); end
        n_checks++; if (wr_count !== exp_wr) begin n_errors++; $display("FAIL basic_wrcnt: got %0d expected %0d", wr_count, exp_wr); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b expected 0", err); end
    endtask

    task automatic test_slow_master();
        bit ok;
        int unsigned u0, l0;
        logic [15:0] w;
        set_rom4(16'h2A55, 16'h3B66, 16'h4C77, 16'hFFFF);
        m_hold = 20;
        obs_rd = obs_q.size();
        u0 = mon_unstable;
        l0 = mon_start_low;
        pulse_start();
        wait_idle(3000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL slow_timeout: got busy %b expected 0", busy); end
        n_checks++; if (mon_unstable != u0) begin n_errors++; $display("FAIL slow_stable: got %0d changes expected 0", mon_unstable - u0); end
        n_checks++; if (mon_start_low != l0) begin n_errors++; $display("FAIL slow_start_low: got %0d expected 0", mon_start_low - l0); end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin n_errors++; $display("FAIL slow_wr: got none expected %h", w); end
            else begin
                if (obs_q[obs_rd] !== w) begin n_errors++; $display("FAIL slow_wr: got %h expected %h", obs_q[obs_rd], w); end
                obs_rd++;
            end
        end
        n_checks++; if (obs_rd != obs_q.size()) begin n_errors++; $display("FAIL slow_extra: got %0d expected %0d", obs_q.size(), obs_rd); end
        n_checks++; if (wr_count !== exp_wr) begin n_errors++; $display("FAIL slow_wrcnt: got %0d expected %0d", wr_count, exp_wr); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        int unsigned nm0;
        logic [15:0] w;
        set_rom4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        m_hold = 5;
        obs_rd = obs_q.size();
        nm0 = mon_nonmono;
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_idle(3000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ign_timeout: got busy %b expected 0", busy); end
        n_checks++; if (mon_nonmono != nm0) begin n_errors++; $display("FAIL ign_mono: got %0d steps back expected 0", mon_nonmono - nm0); end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin n_errors++; $display("FAIL ign_wr: got none expected %h", w); end
            else begin
                if (obs_q[obs_rd] !== w) begin n_errors++; $display("FAIL ign_wr: got %h expected %h", obs_q[obs_rd], w); end
                obs_rd++;
            end
        end
        n_checks++; if (obs_rd != obs_q.size()) begin n_errors++; $display("FAIL ign_extra: got %0d expected %0d", obs_q.size(), obs_rd); end
        n_checks++; if (wr_count !== exp_wr) begin n_errors++; $display("FAIL ign_wrcnt: got %0d expected %0d", wr_count, exp_wr); end
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ign_restart: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        logic [15:0] w;
        set_rom4(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF);
        m_hold = 3;
        pulse_start();
        while (rom_addr !== 8'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (rom_addr !== 8'd1) begin n_errors++; $display("FAIL mid_reach: got addr %h expected 01", rom_addr); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_in_delay: got busy %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (rom_addr !== 8'h0) begin n_errors++; $display("FAIL mid_addr: got %h expected 00", rom_addr); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_checks++; if (sccb_start !== 1'b0) begin n_errors++; $display("FAIL mid_start: got %b expected 0", sccb_start); end
        n_checks++; if (wr_count !== 8'h0) begin n_errors++; $display("FAIL mid_wrcnt0: got %h expected 00", wr_count); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL mid_flags: got %b%b expected 00", done, err); end
        rst = 1'b0;
        build_expect();
        obs_rd = obs_q.size();
        pulse_start();
        wait_idle(2000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL mid_timeout: got busy %b expected 0", busy); end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin n_errors++; $display("FAIL mid_wr: got none expected %h", w); end
            else begin
                if (obs_q[obs_rd] !== w) begin n_errors++; $display("FAIL mid_wr: got %h expected %h", obs_q[obs_rd], w); end
                obs_rd++;
            end
        end
        n_checks++; if (wr_count !== exp_wr) begin n_errors++; $display("FAIL mid_wrcnt: got %0d expected %0d", wr_count, exp_wr); end
    endtask

    task automatic test_no_end();
        bit ok;
        int s0;
        logic [15:0] w;
        for (int a = 0; a < 256; a++) rom[a] = {8'(a), ~8'(a)};
        build_expect();
        m_hold = 1;
        obs_rd = obs_q.size();
        s0 = start_cyc.size();
        pulse_start();
        wait_idle(8000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL noend_timeout: got busy %b expected 0", busy); end
        n_checks++; if (start_cyc.size() - s0 != 256) begin n_errors++; $display("FAIL noend_pulses: got %0d expected 256", start_cyc.size() - s0); end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin n_errors++; $display("FAIL noend_wr: got none expected %h", w); end
            else begin
                if (obs_q[obs_rd] !== w) begin n_errors++; $display("FAIL noend_wr: got %h expected %h", obs_q[obs_rd], w); end
                obs_rd++;
            end
        end
        n_checks++; if (wr_count !== exp_wr) begin n_errors++; $display("FAIL noend_wrcnt: got %0d expected %0d", wr_count, exp_wr); end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL noend_done: got %b expected 1", done); end
        n_checks++; if (rom_addr !== 8'hFF) begin n_errors++; $display("FAIL noend_addr: got %h expected ff", rom_addr); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        int s0;
        logic [7:0] wr_exp;
        logic       err_exp;
        logic [15:0] w;
        set_rom4(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
        m_hold = 3;
        obs_rd = obs_q.size();
        s0 = start_cyc.size();
        m_long_idx = s0;
        pulse_start();
        while (start_cyc.size() == s0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (start_cyc.size() == s0) begin n_errors++; $display("FAIL tmo_issue: got no write expected 1"); end
        repeat (38) @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL tmo_early: got err %b expected 0", err); end
`ifdef CFG_SEQ_TIMEOUT_EN
        wr_exp  = exp_wr - 8'd1;
        err_exp = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL tmo_flag: got err %b expected 1", err); end
`else
        wr_exp  = exp_wr;
        err_exp = 1'b0;
`endif
        wait_idle(2000, ok);
        m_long_idx = -1;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL tmo_timeout: got busy %b expected 0", busy); end
        n_checks++; if (start_cyc.size() - s0 != 2) begin n_errors++; $display("FAIL tmo_pulses: got %0d expected 2", start_cyc.size() - s0); end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin n_errors++; $display("FAIL tmo_wr: got none expected %h", w); end
            else begin
                if (obs_q[obs_rd] !== w) begin n_errors++; $display("FAIL tmo_wr: got %h expected %h", obs_q[obs_rd], w); end
                obs_rd++;
            end
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL tmo_done: got %b expected 1", done); end
        n_checks++; if (wr_count !== wr_exp) begin n_errors++; $display("FAIL tmo_wrcnt: got %0d expected %0d", wr_count, wr_exp); end
        n_checks++; if (err !== err_exp) begin n_errors++; $display("FAIL tmo_err: got %b expected %b", err, err_exp); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
        test_reset();
        test_basic();
        test_slow_master();
        test_start_ignored();
        test_reset_mid();
        test_no_end();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
